// File: rtl/alu_bitcount.sv
// Multi-cycle Zbb bit-count unit: CTZ, CLZ, CPOP and their word variants.
// One operand byte is consumed per cycle, so latency is fixed (9 or 5 cycles).
// CLZ reuses the trailing-count datapath by reversing the operand at capture.
module alu_bitcount #(
  parameter int RISCV_ARCH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ena,
  input  logic [1:0]            i_mode,
  input  logic                  i_rv32,
  input  logic [RISCV_ARCH-1:0] i_a1,
  output logic [RISCV_ARCH-1:0] o_res,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam logic [1:0] ModeCtz  = 2'd0;
  localparam logic [1:0] ModeClz  = 2'd1;
  localparam logic [1:0] ModeCpop = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StProc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [RISCV_ARCH-1:0]   work_q, work_d;
  logic [6:0]              cnt_q, cnt_d;
  logic                    found_q, found_d;
  logic [3:0]              left_q, left_d;
  logic [1:0]              mode_q, mode_d;
  logic [RISCV_ARCH-1:0]   res_q, res_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [RISCV_ARCH-1:0]   opnd;
  logic [7:0]              byte_cur;

  // Trailing zeros of a nonzero byte; zero bytes are handled by the caller.
  function automatic logic [3:0] ctz8(input logic [7:0] b);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++) begin
      r = r + {3'b000, b[i]};
    end
    return r;
  endfunction

  // Operand formatting at capture: word masking and bit reversal for CLZ.
  always_comb begin
    opnd = '0;
    if (i_mode == ModeClz) begin
      if (i_rv32) begin
        for (int i = 0; i < 32; i++) opnd[i] = i_a1[31-i];
      end else begin
        for (int i = 0; i < RISCV_ARCH; i++) opnd[i] = i_a1[RISCV_ARCH-1-i];
      end
    end else begin
      if (i_rv32) opnd[31:0] = i_a1[31:0];
      else        opnd = i_a1;
    end
  end

  assign byte_cur = work_q[7:0];

  // Next-state and datapath updates for the byte-serial counter.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    left_d  = left_q;
    mode_d  = mode_q;
    res_d   = res_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (i_ena) begin
          work_d  = opnd;
          cnt_d   = 7'd0;
          found_d = 1'b0;
          left_d  = i_rv32 ? 4'd4 : 4'd8;
          mode_d  = i_mode;
          busy_d  = 1'b1;
          state_d = StProc;
        end
      end
      StProc: begin
        if (mode_q == ModeCtz || mode_q == ModeClz) begin
          if (!found_q) begin
            if (byte_cur == 8'd0) begin
              cnt_d = cnt_q + 7'd8;
            end else begin
              cnt_d   = cnt_q + {3'b000, ctz8(byte_cur)};
              found_d = 1'b1;
            end
          end
        end else if (mode_q == ModeCpop) begin
          cnt_d = cnt_q + {3'b000, popcount8(byte_cur)};
        end
        work_d = work_q >> 8;
        left_d = left_q - 4'd1;
        if (left_q == 4'd1) begin
          // Result register loads only on the edge entering DONE.
          res_d      = '0;
          res_d[6:0] = cnt_d;
          valid_d    = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= 7'd0;
      found_q <= 1'b0;
      left_q  <= 4'd0;
      mode_q  <= 2'd0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      left_q  <= left_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_res   = res_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule
